// File: rtl/writeback_stage.sv
// MEM/WB writeback stage: captures one instruction per cycle, waits on load data,
// drives the register-file write port. Optional retired counter under WB_INSTRET_EN.
module writeback_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  stall,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     exec_data_in,
    input  logic [DATA_W-1:0]     mem_data_in,
    input  logic                  mem_data_valid,
    input  logic [DATA_W-1:0]     next_pc,
    input  logic [DATA_W-1:0]     csr_data_in,
    input  logic [1:0]            res_src,
    input  logic [2:0]            load_funct3,
    input  logic [1:0]            load_offset,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic                  reg_write_in,
    output logic                  busy,
    output logic                  wb_valid,
    output logic                  reg_write_out,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic [DATA_W-1:0]     data_out,
    output logic [63:0]           instret_out
);

    typedef enum logic [1:0] {EMPTY, COMMIT, WAIT_MEM} state_e;

    state_e                state_q;
    logic [1:0]            res_src_q;
    logic [2:0]            funct3_q;
    logic [1:0]            offset_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  reg_write_q;
    logic [DATA_W-1:0]     exec_q;
    logic [DATA_W-1:0]     load_q;
    logic [DATA_W-1:0]     next_pc_q;
    logic [DATA_W-1:0]     csr_q;
    logic [DATA_W-1:0]     load_d;
    logic [DATA_W-1:0]     result;
    logic                  capture;

    logic [31:0] word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign capture = in_valid & ~stall & ~flush & (state_q != WAIT_MEM);

    // Lane selection uses the captured offset; the memory word is little-endian.
    assign word     = mem_data_in[31:0];
    assign half_sel = offset_q[1] ? word[31:16] : word[15:0];

    always_comb begin
        byte_sel = word[7:0];
        case (offset_q)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
    end

    always_comb begin
        load_d = '0;
        case (funct3_q)
            3'b000: load_d = DATA_W'($signed(byte_sel));
            3'b001: load_d = DATA_W'($signed(half_sel));
            3'b010: load_d = DATA_W'($signed(word));
            3'b100: load_d = DATA_W'(byte_sel);
            3'b101: load_d = DATA_W'(half_sel);
            default: load_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            res_src_q   <= '0;
            funct3_q    <= '0;
            offset_q    <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            exec_q      <= '0;
            load_q      <= '0;
            next_pc_q   <= '0;
            csr_q       <= '0;
        end else begin
            if (capture) begin
                res_src_q   <= res_src;
                funct3_q    <= load_funct3;
                offset_q    <= load_offset;
                rd_q        <= rd_in;
                reg_write_q <= reg_write_in;
                exec_q      <= exec_data_in;
                next_pc_q   <= next_pc;
                csr_q       <= csr_data_in;
            end
            case (state_q)
                EMPTY, COMMIT: begin
                    if (capture)
                        state_q <= (res_src == 2'b01) ? WAIT_MEM : COMMIT;
                    else
                        state_q <= EMPTY;
                end
                WAIT_MEM: begin
                    // Flush wins over a same-cycle data-valid; the load is dropped.
                    if (flush) begin
                        state_q <= EMPTY;
                    end else if (mem_data_valid) begin
                        load_q  <= load_d;
                        state_q <= COMMIT;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    always_comb begin
        result = '0;
        case (res_src_q)
            2'b00: result = exec_q;
            2'b01: result = load_q;
            2'b10: result = next_pc_q;
            2'b11: result = csr_q;
            default: result = '0;
        endcase
    end

    assign wb_valid      = (state_q == COMMIT);
    assign busy          = (state_q == WAIT_MEM);
    assign reg_write_out = wb_valid & reg_write_q & (rd_q != '0);
    assign rd_out        = wb_valid ? rd_q : '0;
    assign data_out      = wb_valid ? result : '0;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            instret_q <= '0;
        else if (wb_valid)
            instret_q <= instret_q + 64'd1;
    end

    assign instret_out = instret_q;
`else
    assign instret_out = 64'h0;
`endif

endmodule
